// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes and controller state encoding
// for the load/store unit memory controller.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RMW_RD,
    RMW_WR,
    RESP,
    ERR
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: core request/response and SRAM strobe bundle.
// slave = controller side, master = core plus SRAM side.
interface lsu_mem_ctrl_if #(
  parameter int WORD_SIZE = 32
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [WORD_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_wdata;

  logic                 resp_valid;
  logic [WORD_SIZE-1:0] resp_rdata;
  logic                 resp_err;

  logic                 mem_re;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, mem_re, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, mem_re, mem_we,
    input  mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: load byte/half extract with sign/zero extension and
// store byte/half merge into a previously read word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [2:0]           funct3,
  input  logic [1:0]           off,
  input  logic [WORD_SIZE-1:0] ld_word,
  input  logic [WORD_SIZE-1:0] st_old,
  input  logic [WORD_SIZE-1:0] st_data,
  output logic [WORD_SIZE-1:0] ld_data,
  output logic [WORD_SIZE-1:0] st_word
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = ld_word[{off, 3'b000} +: 8];
  assign h = off[1] ? ld_word[WORD_SIZE-1:16] : ld_word[15:0];

  always_comb begin
    ld_data = '0;
    unique case (1'b1)
      (funct3 == F3_B):  ld_data = {{(WORD_SIZE-8){b[7]}}, b};
      (funct3 == F3_BU): ld_data = {{(WORD_SIZE-8){1'b0}}, b};
      (funct3 == F3_H):  ld_data = {{(WORD_SIZE-16){h[15]}}, h};
      (funct3 == F3_HU): ld_data = {{(WORD_SIZE-16){1'b0}}, h};
      (funct3 == F3_W):  ld_data = ld_word;
      default:           ld_data = '0;
    endcase
  end

  // half stores pick the lane from off[1] only; off[0] is ignored
  always_comb begin
    st_word = st_old;
    unique case (1'b1)
      (funct3 == F3_B): st_word[{off, 3'b000} +: 8] = st_data[7:0];
      (funct3 == F3_H): begin
        if (off[1]) st_word[WORD_SIZE-1:16] = st_data[15:0];
        else        st_word[15:0] = st_data[15:0];
      end
      (funct3 == F3_W): st_word = st_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator to a word-addressed SRAM with
// RMW for SB/SH. Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  lsu_mem_ctrl_if.slave bus
);

  lsu_state_t state_q, state_d;

  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] merge_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic [2:0]           f3_q;
  logic [WORD_SIZE-1:0] ld_data;
  logic [WORD_SIZE-1:0] st_word;
  logic                 accept;
  logic                 reject;

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    reject = (bus.req_addr >= WORD_SIZE'(MEM_BYTES))
      || !(bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
      || (bus.req_we && (bus.req_funct3 inside {F3_BU, F3_HU}));
`ifdef LSU_MISALIGN_CHECK_EN
    if ((bus.req_funct3 inside {F3_H, F3_HU}) && bus.req_addr[0])
      reject = 1'b1;
    if ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00))
      reject = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject)                      state_d = ERR;
          else if (!bus.req_we)            state_d = LOAD;
          else if (bus.req_funct3 == F3_W) state_d = WRITE;
          else                             state_d = RMW_RD;
        end
      end
      LOAD, WRITE, RMW_WR: state_d = RESP;
      RMW_RD:              state_d = RMW_WR;
      RESP, ERR:           state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        f3_q    <= bus.req_funct3;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
      end
      if (state_q == LOAD)   rdata_q <= ld_data;
      if (state_q == RMW_RD) merge_q <= bus.mem_rdata;
    end
  end

  lsu_align #(
    .WORD_SIZE(WORD_SIZE)
  ) u_align (
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .ld_word(bus.mem_rdata),
    .st_old (merge_q),
    .st_data(wdata_q),
    .ld_data(ld_data),
    .st_word(st_word)
  );

  // strobes depend on state only, never on the live request
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_rdata = rdata_q;
    bus.mem_addr   = {addr_q[WORD_SIZE-1:2], 2'b00};
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = '0;
    unique case (state_q)
      LOAD:   bus.mem_re = 1'b1;
      RMW_RD: bus.mem_re = 1'b1;
      WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = wdata_q;
      end
      RMW_WR: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = st_word;
      end
      RESP: bus.resp_valid = 1'b1;
      ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the core's memory stage and the word-addressed data SRAM.
- Accepts one load or store per handshake and issues SRAM read/write strobes.
- Performs read-modify-write for SB/SH, since the SRAM has no byte enables.
- Extracts and sign/zero-extends LB/LH/LBU/LHU data, then returns a single-cycle response.

Parameters:
- WORD_SIZE, 32, data/address width; fixed at 32 for RV32 funct3 semantics.
- MEM_BYTES, 1024, byte span of the attached SRAM; byte addresses at or above this are out of range.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  core request present
- req_ready  output  1  controller can accept a request (IDLE only)
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  WORD_SIZE  byte address
- req_wdata  input  WORD_SIZE  store data, right-aligned
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  WORD_SIZE  extended load data; 0 for stores/errors
- resp_err  output  1  access rejected, no SRAM write performed
- mem_re  output  1  SRAM read_enable
- mem_we  output  1  SRAM write_enable
- mem_addr  output  WORD_SIZE  word-aligned address, bits[1:0]=0
- mem_wdata  output  WORD_SIZE  SRAM data_in
- mem_rdata  input  WORD_SIZE  SRAM data_out; combinational, valid only while mem_re=1 (high-Z otherwise)

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; request registers and resp_rdata clear to 0.
  - resp_valid, resp_err, mem_re, mem_we = 0; mem_addr = mem_wdata = 0.
- Handshake:
  - A request is accepted on an edge where req_valid & req_ready.
  - The addr, funct3, we and wdata fields are registered at acceptance; core inputs are ignored afterwards.
  - req_ready = (state==IDLE).
- mem_re, mem_we, mem_addr and mem_wdata are decoded from registered state only, with no combinational path from req_*.
- States:
  - IDLE: wait for acceptance. On acceptance go to ERR if the request is rejected, LOAD for loads, WRITE for SW, RMW_RD for SB/SH.
  - LOAD: mem_re=1. Sample mem_rdata, extract the byte/half/word selected by addr[1:0], sign-extend (B/H) or zero-extend (BU/HU) into resp_rdata. Go to RESP.
  - WRITE: mem_we=1, mem_wdata=req_wdata. Go to RESP.
  - RMW_RD: mem_re=1. Capture mem_rdata into a merge register. Go to RMW_WR.
  - RMW_WR: mem_we=1. mem_wdata = captured word with the byte (addr[1:0]) or half (addr[1]) replaced by req_wdata[7:0]/[15:0]. Go to RESP.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0. Go to IDLE.
  - RESP: resp_valid=1, resp_err=0. Go to IDLE.
- Latency from acceptance edge to resp_valid cycle:
  - 2 cycles: loads, SW.
  - 3 cycles: SB/SH.
  - 1 cycle: errors.
- Throughput: a new request can be accepted in the cycle after resp_valid.
- Rejection (always active): addr >= MEM_BYTES; funct3 not in {000,001,010,100,101}; store with funct3 100/101.
- mem_rdata is sampled only in LOAD/RMW_RD.
- Reset mid-operation:
  - Return to IDLE next edge with no response.
  - The SRAM write of the cycle in which rst is asserted still completes, because strobes come from current state.
  - A partially completed RMW never writes after reset.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: H access with addr[0]=1, or W access with addr[1:0]!=0, is rejected via ERR; no SRAM access occurs.
- Undefined: no alignment check.
  - H uses addr[1] only.
  - W ignores addr[1:0].
  - resp_err is driven only by the always-active rejections.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - typedef enum lsu_state_t {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP, ERR}.
- Sub-module lsu_align (combinational) holds load extract/extend and store byte/half merge functions, keeping the controller FSM-only.

Test Plan:
- Reset: rst=1 for 2 cycles → all outputs 0, req_ready=1 after release.
- Store/load word: SW addr 0x10, data 0xDEADBEEF → mem_we one cycle with mem_addr 0x10, resp_valid at +2. LW 0x10 → resp_rdata 0xDEADBEEF at +2.
- Byte RMW and extension, starting from word 0xDEADBEEF at 0x10:
  - SB addr 0x11, data 0x55 → mem_re then mem_we, mem_wdata 0xDEAD55EF, resp at +3.
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD.
- Out of range: LW addr 0x400 → no mem_re/mem_we, resp_err=1 at +1. Bad funct3 011 → same.
- Misalign, macro defined: LH 0x11 → resp_err=1, no SRAM access. Macro undefined: LH 0x11 → resp_err=0, data from half at addr[1]=0.
- Reset mid-RMW: assert rst in the RMW_RD cycle of SB 0x20 → no mem_we follows, no resp_valid, word 0x20 unchanged.
